// File: rtl/serial_adder.sv
// Bit-serial adder: one full-adder cell plus carry flop, LSB first, start/busy/done handshake.
// Optional subtract mode is built when SERIAL_ADDER_SUB_EN is defined.
module serial_adder #(
  parameter int WIDTH = 8
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             start,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic             c_in,
`ifdef SERIAL_ADDER_SUB_EN
  input  logic             sub,
`endif
  output logic [WIDTH-1:0] sum,
  output logic             c_out,
  output logic             busy,
  output logic             done
);

  localparam int CW = (WIDTH > 2) ? $clog2(WIDTH) : 1;
  localparam logic [CW-1:0] LAST_CNT = CW'(WIDTH - 1);

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_RUN  = 2'd1,
    ST_DONE = 2'd2
  } state_t;

  state_t           state_r;
  state_t           state_nxt_s;
  logic             accept_s;
  logic [WIDTH-1:0] sa_r;
  logic [WIDTH-1:0] sb_r;
  logic [WIDTH-1:0] ss_r;
  logic             cy_r;
  logic [CW-1:0]    cnt_r;
  logic [WIDTH-1:0] sum_r;
  logic             c_out_r;
  logic             busy_r;
  logic             done_r;
  logic             fa_sum_s;
  logic             fa_cy_s;
  logic [WIDTH-1:0] ld_b_s;
  logic             ld_cy_s;

  function automatic logic maj3(input logic x, input logic y, input logic z);
    return (x & y) | (x & z) | (y & z);
  endfunction

  // Next-state decode and operand-acceptance strobe
  always_comb begin
    state_nxt_s = state_r;
    accept_s    = 1'b0;
    case (state_r)
      ST_IDLE: begin
        if (start) begin
          accept_s    = 1'b1;
          state_nxt_s = ST_RUN;
        end else begin
          state_nxt_s = ST_IDLE;
        end
      end
      ST_RUN: begin
        if (cnt_r == LAST_CNT) begin
          state_nxt_s = ST_DONE;
        end else begin
          state_nxt_s = ST_RUN;
        end
      end
      ST_DONE: begin
        if (start) begin
          accept_s    = 1'b1;
          state_nxt_s = ST_RUN;
        end else begin
          state_nxt_s = ST_IDLE;
        end
      end
      default: begin
        state_nxt_s = ST_IDLE;
      end
    endcase
  end

  // Full-adder cell and load values (subtract = add inverted B with carry-in forced high)
  always_comb begin
    fa_sum_s = sa_r[0] ^ sb_r[0] ^ cy_r;
    fa_cy_s  = maj3(sa_r[0], sb_r[0], cy_r);
    ld_b_s   = b;
    ld_cy_s  = c_in;
`ifdef SERIAL_ADDER_SUB_EN
    if (sub) begin
      ld_b_s  = ~b;
      ld_cy_s = 1'b1;
    end else begin
      ld_b_s  = b;
      ld_cy_s = c_in;
    end
`endif
  end

  // State, datapath shift registers and registered outputs
  always_ff @(posedge clk) begin
    if (reset) begin
      state_r <= ST_IDLE;
      sa_r    <= {WIDTH{1'b0}};
      sb_r    <= {WIDTH{1'b0}};
      ss_r    <= {WIDTH{1'b0}};
      cy_r    <= 1'b0;
      cnt_r   <= {CW{1'b0}};
      sum_r   <= {WIDTH{1'b0}};
      c_out_r <= 1'b0;
      busy_r  <= 1'b0;
      done_r  <= 1'b0;
    end else begin
      state_r <= state_nxt_s;
      busy_r  <= (state_nxt_s == ST_RUN);
      done_r  <= (state_nxt_s == ST_DONE);
      if (accept_s) begin
        sa_r  <= a;
        sb_r  <= ld_b_s;
        cy_r  <= ld_cy_s;
        cnt_r <= {CW{1'b0}};
      end else if (state_r == ST_RUN) begin
        sa_r  <= {1'b0, sa_r[WIDTH-1:1]};
        sb_r  <= {1'b0, sb_r[WIDTH-1:1]};
        ss_r  <= {fa_sum_s, ss_r[WIDTH-1:1]};
        cy_r  <= fa_cy_s;
        cnt_r <= cnt_r + {{(CW-1){1'b0}}, 1'b1};
        // Last bit: publish the sum including the bit being produced this cycle
        if (cnt_r == LAST_CNT) begin
          sum_r   <= {fa_sum_s, ss_r[WIDTH-1:1]};
          c_out_r <= fa_cy_s;
        end
      end
    end
  end

  assign sum   = sum_r;
  assign c_out = c_out_r;
  assign busy  = busy_r;
  assign done  = done_r;

endmodule

// File: tb/tb_serial_adder.sv
// Self-checking bench for serial_adder: directed cases plus random operands against an arithmetic model.
module tb_serial_adder;

  localparam int W = 8;

  logic         clk;
  logic         reset;
  logic         start;
  logic [W-1:0] a;
  logic [W-1:0] b;
  logic         c_in;
  logic         sub;
  logic [W-1:0] sum;
  logic         c_out;
  logic         busy;
  logic         done;

  int checks = 0;
  int errors = 0;

  serial_adder #(.WIDTH(W)) dut (
    .clk   (clk),
    .reset (reset),
    .start (start),
    .a     (a),
    .b     (b),
    .c_in  (c_in),
`ifdef SERIAL_ADDER_SUB_EN
    .sub   (sub),
`endif
    .sum   (sum),
    .c_out (c_out),
    .busy  (busy),
    .done  (done)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got %0h expected %0h", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  function automatic logic [W:0] ref_model(input logic [W-1:0] x, input logic [W-1:0] y,
                                           input logic c, input logic s);
    if (s) return {(x >= y) ? 1'b1 : 1'b0, W'(x - y)};
    else   return (W+1)'(x) + (W+1)'(y) + (W+1)'(c);
  endfunction

  // Start an operation (accepted at the next edge) and follow it to done.
  // poke bit k: pulse start with junk operands while in RUN after edge Ek.
  task automatic op(input logic [W-1:0] ta, input logic [W-1:0] tb_v, input logic tc,
                    input logic ts, input int poke);
    logic [W:0] exp;
    int n;
    int busy_n;
    exp   = ref_model(ta, tb_v, tc, ts);
    a     = ta;
    b     = tb_v;
    c_in  = tc;
    sub   = ts;
    start = 1'b1;
    tick();
    start  = 1'b0;
    n      = 1;
    busy_n = 0;
    while (done !== 1'b1 && n < 3 * W) begin
      if (busy === 1'b1) busy_n++;
      if (poke[n % 32] && n < W - 1) begin
        start = 1'b1;
        a     = W'($urandom);
        b     = W'($urandom);
        c_in  = 1'($urandom);
      end else begin
        start = 1'b0;
      end
      tick();
      n++;
    end
    start = 1'b0;
    check("latency_edges", n, W + 1);
    check("busy_cycles", busy_n, W);
    check("busy_at_done", {31'd0, busy}, 32'd0);
    check("sum", {24'd0, sum}, {24'd0, exp[W-1:0]});
    check("c_out", {31'd0, c_out}, {31'd0, exp[W]});
  endtask

  task automatic idle_after_done();
    start = 1'b0;
    tick();
    check("done_one_cycle", {31'd0, done}, 32'd0);
    check("busy_idle", {31'd0, busy}, 32'd0);
  endtask

  initial begin
    logic [W:0] held;
    logic       ts;
    bit         saw_done;
    reset = 1'b1;
    start = 1'b1;
    a     = 8'h5A;
    b     = 8'h33;
    c_in  = 1'b1;
    sub   = 1'b0;
    tick();
    tick();
    check("rst_sum", {24'd0, sum}, 32'd0);
    check("rst_c_out", {31'd0, c_out}, 32'd0);
    check("rst_busy", {31'd0, busy}, 32'd0);
    check("rst_done", {31'd0, done}, 32'd0);
    reset = 1'b0;
    start = 1'b0;
    tick();
    check("no_op_after_rst", {31'd0, busy}, 32'd0);

    op(8'h00, 8'h00, 1'b0, 1'b0, 0);
    idle_after_done();
    op(8'hFF, 8'h01, 1'b0, 1'b0, 0);
    idle_after_done();
    op(8'hA5, 8'h5A, 1'b1, 1'b0, 0);
    idle_after_done();
    op(8'h3C, 8'h0F, 1'b0, 1'b0, (1 << 3) | (1 << 5));

    // Back-to-back: start accepted in the DONE cycle
    held = ref_model(8'h3C, 8'h0F, 1'b0, 1'b0);
    a     = 8'h01;
    b     = 8'h02;
    c_in  = 1'b0;
    start = 1'b1;
    tick();
    start = 1'b0;
    check("b2b_busy", {31'd0, busy}, 32'd1);
    check("b2b_done_low", {31'd0, done}, 32'd0);
    check("b2b_sum_held", {24'd0, sum}, {24'd0, held[W-1:0]});
    saw_done = 1'b0;
    for (int i = 0; i < 3 * W && !saw_done; i++) begin
      tick();
      if (done === 1'b1) saw_done = 1'b1;
    end
    check("b2b_saw_done", {31'd0, saw_done}, 32'd1);
    check("b2b_sum", {24'd0, sum}, 32'h03);
    idle_after_done();

    // Reset mid-operation
    op(8'hC3, 8'h7E, 1'b1, 1'b0, 0);
    idle_after_done();
    a     = 8'h12;
    b     = 8'h34;
    start = 1'b1;
    tick();
    start = 1'b0;
    for (int i = 0; i < 3; i++) tick();
    reset = 1'b1;
    tick();
    reset = 1'b0;
    check("midrst_sum", {24'd0, sum}, 32'd0);
    check("midrst_c_out", {31'd0, c_out}, 32'd0);
    check("midrst_busy", {31'd0, busy}, 32'd0);
    check("midrst_done", {31'd0, done}, 32'd0);
    saw_done = 1'b0;
    for (int i = 0; i < W + 3; i++) begin
      tick();
      if (done === 1'b1 || busy === 1'b1) saw_done = 1'b1;
    end
    check("midrst_quiet", {31'd0, saw_done}, 32'd0);
    op(8'h80, 8'h80, 1'b1, 1'b0, 0);
    idle_after_done();

`ifdef SERIAL_ADDER_SUB_EN
    op(8'h05, 8'h07, 1'b1, 1'b1, 0);
    idle_after_done();
    op(8'h07, 8'h05, 1'b0, 1'b1, 0);
    idle_after_done();
    op(8'h80, 8'h80, 1'b1, 1'b1, 0);
    idle_after_done();
`endif

    // Random operands, random idle gaps or back-to-back issue
    for (int k = 0; k < 40; k++) begin
`ifdef SERIAL_ADDER_SUB_EN
      ts = 1'($urandom);
`else
      ts = 1'b0;
`endif
      op(W'($urandom), W'($urandom), 1'($urandom), ts, int'($urandom & 32'h3E));
      if ($urandom_range(0, 1) == 0) idle_after_done();
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
